mips_mem_arbiter: RTL and testbench
===================================

// Module: mips_mem_arbiter
// PURPOSE
//  Arbitrates one single-port word memory between three requesters of the
//  pipelined MIPS32 core: instruction fetch (IF), data memory stage (DM) and
//  debug/program loader (DBG). Sits between the pipeline and the shared Mem
//  array. Priority is DBG > DM > IF, with a starvation guard for IF.
//  One transaction is in flight at a time; each request is completed with a
//  one-cycle ack.
// PARAMETERS
//  AW          10  word-address width
//  DW          32  data width
//  MEM_LAT     1   memory read latency in cycles, >=1: mem_rdata is valid MEM_LAT cycles after mem_en
//  STARVE_LIM  4   number of consecutive IF losses before IF outranks DM, >=1
// PORTS
//  clk1       in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  if_req     in   1   IF read request, held until if_ack
//  if_addr    in   AW  IF word address
//  if_ack     out  1   one-cycle completion pulse
//  if_rdata   out  DW  fetched word, valid while if_ack=1
//  dm_req     in   1   DM request, held until dm_ack
//  dm_we      in   1   1=store 0=load
//  dm_addr    in   AW  DM word address
//  dm_wdata   in   DW  store data
//  dm_ack     out  1   one-cycle completion pulse
//  dm_rdata   out  DW  load data, valid while dm_ack=1
//  dbg_req    in   1   DBG request, held until dbg_ack
//  dbg_we     in   1   1=write 0=read
//  dbg_addr   in   AW  DBG word address
//  dbg_wdata  in   DW  DBG write data
//  dbg_ack    out  1   one-cycle completion pulse
//  dbg_rdata  out  DW  DBG read data, valid while dbg_ack=1
//  mem_en     out  1   memory access strobe, exactly 1 cycle per transaction
//  mem_we     out  1   memory write enable, only with mem_en
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data
//  grant_id   out  2   current owner: 0=IF 1=DM 2=DBG 3=none
//  busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, immediate) clears all outputs to 0 and sets grant_id=3.
//  State, starve_cnt and latch registers also reset: state=IDLE, starve_cnt=0.
//  FSM states: IDLE -> ISSUE -> (read) WAIT -> RESP -> IDLE; (write) ISSUE -> RESP -> IDLE.
//  IDLE: at each edge, sample the reqs. If any req is high:
//   - choose the winner;
//   - latch its addr/we/wdata into mem_*;
//   - set grant_id;
//   - go to ISSUE.
//  ISSUE lasts 1 cycle with mem_en=1 (mem_we=latched we).
//   - Write: goes to RESP.
//   - Read: goes to WAIT.
//  WAIT: counts MEM_LAT-1 further cycles, then captures mem_rdata into the
//   winner's rdata register and goes to RESP. For MEM_LAT=1, WAIT lasts 1 cycle.
//  RESP: the winner's ack is 1 for exactly 1 cycle; its rdata is held until the
//   next ack to that requester. Next state is IDLE; grant_id returns to 3.
//  Latency, with the request sampled at edge E0 while IDLE:
//   - mem_en is high E0..E1;
//   - write ack is high E1..E2;
//   - read ack is high E(MEM_LAT+1)..E(MEM_LAT+2).
//  Requester rules: drop req at the edge that samples its ack=1; keep addr,
//   we and wdata stable while req=1. A req still high in IDLE after RESP is a
//   new request. Input changes while not IDLE are ignored (values are latched).
//  Priority: DBG > DM > IF. Exception: when starve_cnt==STARVE_LIM, IF > DM
//   (DBG still wins).
//  starve_cnt, evaluated at each IDLE grant decision:
//   - +1 if if_req=1 and IF is not granted, saturating at STARVE_LIM;
//   - cleared when IF is granted, or when if_req=0 at a decision.
//  Simultaneous requests: exactly one grant per decision; losers keep waiting
//   with no ack.
//  Reset mid-transaction: aborts the transaction; no ack for the aborted
//   request; the requester must re-request. A memory write already strobed is
//   not undone.
//  Only one ack is ever high in a given cycle; ack never rises without a prior mem_en.
// TESTING
//  1. Single IF read of addr 5, Mem[5]=0x2801000a, MEM_LAT=1 -> mem_en E0..E1; if_ack E2..E3 with if_rdata=0x2801000a.
//  2. DM store 0x0000001e to addr 20, then DM load of addr 20 -> dm_ack E1 for the store; the load returns 0x0000001e; mem_we=1 only during the store's ISSUE cycle.
//  3. if_req, dm_req and dbg_req all high at once -> grant order DBG, DM, IF; exactly 3 acks; never 2 acks in one cycle.
//  4. DM requests back-to-back while if_req is held, STARVE_LIM=4 -> IF granted at the 5th decision, then starve_cnt=0.
//  5. Reset asserted during WAIT of a DM read -> all outputs 0 immediately; grant_id=3; no dm_ack; a re-request completes normally.
//  6. MEM_LAT=3 read of addr 7 -> ack high E4..E5; rdata equals the value sampled 3 cycles after mem_en.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// Shared single-port memory arbiter for the MIPS32 core: instruction fetch, data
// memory and debug/loader requesters, one transaction in flight, one-cycle ack each.
module mips_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk1,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant_id,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int SW  = $clog2(STARVE_LIM + 1);
  localparam int WCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(MEM_LAT - 1);
  localparam logic [1:0] GID_IF   = 2'd0;
  localparam logic [1:0] GID_DM   = 2'd1;
  localparam logic [1:0] GID_DBG  = 2'd2;
  localparam logic [1:0] GID_NONE = 2'd3;

  state_t         state_r, state_s;
  logic [1:0]     win_s;
  logic           any_req_s;
  logic           win_we_s;
  logic [AW-1:0]  win_addr_s;
  logic [DW-1:0]  win_wdata_s;
  logic           we_r, we_s;
  logic [SW-1:0]  starve_r, starve_s;
  logic [WCW-1:0] wait_cnt_r, wait_cnt_s;
  logic [1:0]     grant_r, grant_s;
  logic           mem_en_r, mem_en_s;
  logic           mem_we_r, mem_we_s;
  logic [AW-1:0]  mem_addr_r, mem_addr_s;
  logic [DW-1:0]  mem_wdata_r, mem_wdata_s;
  logic           resp_s, cap_s;
  logic           if_ack_r, dm_ack_r, dbg_ack_r, busy_r;
  logic [DW-1:0]  if_rdata_r, dm_rdata_r, dbg_rdata_r;

  // Winner selection: debug always first; a starved fetch jumps ahead of data.
  always_comb begin
    win_s = GID_NONE;
    if (dbg_req) begin
      win_s = GID_DBG;
    end else if (if_req && (starve_r == STARVE_MAX)) begin
      win_s = GID_IF;
    end else if (dm_req) begin
      win_s = GID_DM;
    end else if (if_req) begin
      win_s = GID_IF;
    end else begin
      win_s = GID_NONE;
    end
  end

  assign any_req_s = (win_s != GID_NONE);

  // Route the winner's address, direction and store data toward the latch.
  always_comb begin
    win_we_s    = 1'b0;
    win_addr_s  = mem_addr_r;
    win_wdata_s = mem_wdata_r;
    case (win_s)
      GID_DBG: begin
        win_we_s    = dbg_we;
        win_addr_s  = dbg_addr;
        win_wdata_s = dbg_wdata;
      end
      GID_DM: begin
        win_we_s    = dm_we;
        win_addr_s  = dm_addr;
        win_wdata_s = dm_wdata;
      end
      GID_IF: begin
        win_we_s    = 1'b0;
        win_addr_s  = if_addr;
        win_wdata_s = {DW{1'b0}};
      end
      default: begin
        win_we_s    = 1'b0;
        win_addr_s  = mem_addr_r;
        win_wdata_s = mem_wdata_r;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: writes skip WAIT, reads wait out the memory latency.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) state_s = ISSUE;
        else           state_s = IDLE;
      end
      ISSUE: begin
        if (we_r) state_s = RESP;
        else      state_s = WAIT;
      end
      WAIT: begin
        if (wait_cnt_r == WAIT_LAST) state_s = RESP;
        else                         state_s = WAIT;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output and datapath next values, registered below.
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    we_s        = we_r;
    grant_s     = grant_r;
    starve_s    = starve_r;
    wait_cnt_s  = wait_cnt_r;
    resp_s      = 1'b0;
    cap_s       = 1'b0;
    case (state_r)
      IDLE: begin
        wait_cnt_s = {WCW{1'b0}};
        if (if_req && (win_s != GID_IF)) begin
          if (starve_r == STARVE_MAX) starve_s = starve_r;
          else                        starve_s = starve_r + SW'(1'b1);
        end else begin
          starve_s = {SW{1'b0}};
        end
        if (any_req_s) begin
          mem_en_s    = 1'b1;
          mem_we_s    = win_we_s;
          mem_addr_s  = win_addr_s;
          mem_wdata_s = win_wdata_s;
          we_s        = win_we_s;
          grant_s     = win_s;
        end else begin
          grant_s = GID_NONE;
        end
      end
      ISSUE: begin
        if (we_r) resp_s = 1'b1;
        else      resp_s = 1'b0;
      end
      WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          resp_s = 1'b1;
          cap_s  = 1'b1;
        end else begin
          wait_cnt_s = wait_cnt_r + WCW'(1'b1);
        end
      end
      RESP:    grant_s = GID_NONE;
      default: grant_s = GID_NONE;
    endcase
  end

  // Datapath, ack and read-data registers; rdata holds until that requester's next read.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      we_r        <= 1'b0;
      grant_r     <= GID_NONE;
      starve_r    <= {SW{1'b0}};
      wait_cnt_r  <= {WCW{1'b0}};
      if_ack_r    <= 1'b0;
      dm_ack_r    <= 1'b0;
      dbg_ack_r   <= 1'b0;
      busy_r      <= 1'b0;
      if_rdata_r  <= {DW{1'b0}};
      dm_rdata_r  <= {DW{1'b0}};
      dbg_rdata_r <= {DW{1'b0}};
    end else begin
      mem_en_r    <= mem_en_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      we_r        <= we_s;
      grant_r     <= grant_s;
      starve_r    <= starve_s;
      wait_cnt_r  <= wait_cnt_s;
      if_ack_r    <= resp_s && (grant_r == GID_IF);
      dm_ack_r    <= resp_s && (grant_r == GID_DM);
      dbg_ack_r   <= resp_s && (grant_r == GID_DBG);
      busy_r      <= (state_s != IDLE);
      if (cap_s && (grant_r == GID_IF))  if_rdata_r  <= mem_rdata;
      if (cap_s && (grant_r == GID_DM))  dm_rdata_r  <= mem_rdata;
      if (cap_s && (grant_r == GID_DBG)) dbg_rdata_r <= mem_rdata;
    end
  end

  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign grant_id  = grant_r;
  assign busy      = busy_r;
  assign if_ack    = if_ack_r;
  assign dm_ack    = dm_ack_r;
  assign dbg_ack   = dbg_ack_r;
  assign if_rdata  = if_rdata_r;
  assign dm_rdata  = dm_rdata_r;
  assign dbg_rdata = dbg_rdata_r;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_mips_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic b_rst = 1'b1;

  logic          if_req = 1'b0, dm_req = 1'b0, dbg_req = 1'b0, dm_we = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0, dbg_addr = '0;
  logic [DW-1:0] dm_wdata = '0, dbg_wdata = '0;
  logic          if_ack, dm_ack, dbg_ack, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, dm_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    grant_id;

  logic          b_if_req = 1'b0, b_dm_req = 1'b0, b_dbg_req = 1'b0, b_dm_we = 1'b0, b_dbg_we = 1'b0;
  logic [AW-1:0] b_if_addr = '0, b_dm_addr = '0, b_dbg_addr = '0;
  logic [DW-1:0] b_dm_wdata = '0, b_dbg_wdata = '0;
  logic          b_if_ack, b_dm_ack, b_dbg_ack, b_mem_en, b_mem_we, b_busy;
  logic [DW-1:0] b_if_rdata, b_dm_rdata, b_dbg_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0] b_mem_addr;
  logic [1:0]    b_grant_id;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int n_ack, multi;
  logic [31:0] order;

  mips_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_LIM(4)) dut_a (
    .clk1(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_id(grant_id), .busy(busy)
  );

  mips_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_LIM(4)) dut_b (
    .clk1(clk), .reset(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
    .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
    .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .grant_id(b_grant_id), .busy(b_busy)
  );

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    case (a)
      10'd5:   init_word = 32'h2801000a;
      10'd6:   init_word = 32'h00430820;
      10'd7:   init_word = 32'h12345678;
      default: init_word = {22'd0, a};
    endcase
  endfunction

  // Memory model A: read data valid only during the one cycle MEM_LAT=1 after the strobe.
  bit            wr_a  [0:1023];
  logic [DW-1:0] mem_a [0:1023];
  logic          va = 1'b0;
  logic [DW-1:0] da = '0;
  always @(posedge clk) begin
    va <= mem_en && !mem_we;
    da <= wr_a[mem_addr] ? mem_a[mem_addr] : init_word(mem_addr);
    if (mem_en && mem_we) begin
      mem_a[mem_addr] <= mem_wdata;
      wr_a[mem_addr]  <= 1'b1;
    end
  end
  assign mem_rdata = va ? da : 32'hdeadbeef;

  // Memory model B: three-stage read pipeline, garbage outside the valid slot.
  logic          vb1 = 1'b0, vb2 = 1'b0, vb3 = 1'b0;
  logic [DW-1:0] db1 = '0, db2 = '0, db3 = '0;
  always @(posedge clk) begin
    vb1 <= b_mem_en && !b_mem_we;
    db1 <= init_word(b_mem_addr);
    vb2 <= vb1;
    db2 <= db1;
    vb3 <= vb2;
    db3 <= db2;
  end
  assign b_mem_rdata = vb3 ? db3 : 32'hdeadbeef;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_grant", grant_id, 32'd3);
    chk("rst_outs", {busy, mem_en, mem_we, if_ack, dm_ack, dbg_ack}, 32'd0);
    chk("rst_data", mem_addr | mem_wdata | if_rdata | dm_rdata | dbg_rdata, 32'd0);
    chk("b_rst_grant", b_grant_id, 32'd3);
    chk("b_rst_outs", {b_busy, b_mem_en, b_mem_we, b_if_ack, b_dm_ack, b_dbg_ack}, 32'd0);
    chk("b_rst_data", b_mem_addr | b_mem_wdata | b_if_rdata | b_dm_rdata | b_dbg_rdata, 32'd0);
    rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);

    // Single IF read of address 5
    if_req = 1'b1; if_addr = 10'd5;
    @(negedge clk);
    chk("t1_issue", {mem_en, mem_we, grant_id, busy}, 32'b1_0_00_1);
    chk("t1_addr", mem_addr, 32'd5);
    chk("t1_ack_e0", if_ack, 32'd0);
    @(negedge clk);
    chk("t1_wait", {mem_en, if_ack}, 32'd0);
    @(negedge clk);
    chk("t1_ack", if_ack, 32'd1);
    chk("t1_rdata", if_rdata, 32'h2801000a);
    if_req = 1'b0;
    @(negedge clk);
    chk("t1_idle", {if_ack, busy, grant_id}, 32'b0_0_11);
    chk("t1_hold", if_rdata, 32'h2801000a);

    // DM store then load of address 20
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd20; dm_wdata = 32'h0000001e;
    @(negedge clk);
    chk("t2_st_issue", {mem_en, mem_we, grant_id}, 32'b1_1_01);
    chk("t2_st_addr", mem_addr, 32'd20);
    chk("t2_st_wdata", mem_wdata, 32'h0000001e);
    @(negedge clk);
    chk("t2_st_ack", {dm_ack, mem_en, mem_we}, 32'b100);
    dm_req = 1'b0;
    @(negedge clk);
    chk("t2_st_done", {dm_ack, busy}, 32'd0);
    dm_req = 1'b1; dm_we = 1'b0;
    @(negedge clk);
    chk("t2_ld_issue", {mem_en, mem_we}, 32'b10);
    @(negedge clk);
    chk("t2_ld_wait", {dm_ack, mem_we}, 32'd0);
    @(negedge clk);
    chk("t2_ld_ack", dm_ack, 32'd1);
    chk("t2_ld_rdata", dm_rdata, 32'h0000001e);
    dm_req = 1'b0;
    @(negedge clk);

    // Three simultaneous requests: DBG, then DM, then IF
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd30; dbg_wdata = 32'hcafe0030;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd20;
    if_req = 1'b1; if_addr = 10'd5;
    n_ack = 0; multi = 0; order = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((int'(if_ack) + int'(dm_ack) + int'(dbg_ack)) > 1) multi++;
      if (dbg_ack) begin order = {order[29:0], 2'd2}; n_ack++; dbg_req = 1'b0; end
      if (dm_ack)  begin order = {order[29:0], 2'd1}; n_ack++; dm_req = 1'b0; end
      if (if_ack)  begin order = {order[29:0], 2'd0}; n_ack++; if_req = 1'b0; end
      if (n_ack >= 3) break;
    end
    chk("t3_acks", n_ack, 32'd3);
    chk("t3_order", order, 32'h24);
    chk("t3_multi", multi, 32'd0);
    chk("t3_dm_rdata", dm_rdata, 32'h0000001e);
    chk("t3_if_rdata", if_rdata, 32'h2801000a);
    @(negedge clk);

    // Starvation: DM hammers with stores while IF keeps requesting
    if_req = 1'b1; if_addr = 10'd6;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd40; dm_wdata = 32'h00000044;
    n_ack = 0; multi = 0; order = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if ((int'(if_ack) + int'(dm_ack) + int'(dbg_ack)) > 1) multi++;
      if (dm_ack) begin order = {order[29:0], 2'd1}; n_ack++; end
      if (if_ack) begin order = {order[29:0], 2'd0}; n_ack++; end
      if (n_ack >= 6) dm_req = 1'b0;
      if (n_ack >= 7) begin if_req = 1'b0; break; end
    end
    chk("t4_acks", n_ack, 32'd7);
    chk("t4_order", order, 32'h1544);
    chk("t4_multi", multi, 32'd0);
    chk("t4_if_rdata", if_rdata, 32'h00430820);
    @(negedge clk);

    // Reset during the WAIT of a DM read, then re-request
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd5;
    @(negedge clk);
    chk("t5_issue", {mem_en, grant_id}, 32'b1_01);
    @(negedge clk);
    chk("t5_in_wait", {busy, mem_en, dm_ack}, 32'b100);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_grant", grant_id, 32'd3);
    chk("t5_rst_outs", {busy, mem_en, mem_we, if_ack, dm_ack, dbg_ack}, 32'd0);
    chk("t5_rst_addr", mem_addr, 32'd0);
    chk("t5_rst_rdata", dm_rdata, 32'd0);
    @(negedge clk);
    chk("t5_no_ack", dm_ack, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_reissue", {mem_en, grant_id}, 32'b1_01);
    @(negedge clk);
    chk("t5_re_wait", dm_ack, 32'd0);
    @(negedge clk);
    chk("t5_re_ack", dm_ack, 32'd1);
    chk("t5_re_rdata", dm_rdata, 32'h2801000a);
    dm_req = 1'b0;
    @(negedge clk);

    // MEM_LAT=3 debug read of address 7
    b_dbg_req = 1'b1; b_dbg_we = 1'b0; b_dbg_addr = 10'd7;
    @(negedge clk);
    chk("t6_issue", {b_mem_en, b_mem_we, b_grant_id}, 32'b1_0_10);
    chk("t6_addr", b_mem_addr, 32'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t6_ack_e3", {b_dbg_ack, b_busy}, 32'b01);
    @(negedge clk);
    chk("t6_ack_e4", b_dbg_ack, 32'd1);
    chk("t6_rdata", b_dbg_rdata, 32'h12345678);
    b_dbg_req = 1'b0;
    @(negedge clk);
    chk("t6_idle", {b_dbg_ack, b_busy, b_grant_id}, 32'b0_0_11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
